// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
//   Parametrised multi-port register file with a per-register busy scoreboard.
//   Decode reads operands and marks destinations pending (busy set); writeback
//   writes results and clears the pending bit of the written register.
//
// Parameters
//   DATA_W   register width
//   NUM_REGS number of registers (>= 2); ADDR_W = $clog2(NUM_REGS)
//   NUM_RD   number of read ports (>= 1)
//   NUM_WR   number of write ports (>= 1)
//   ZERO_REG 1: register 0 reads 0, ignores writes, never goes busy
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   rd_addr        NUM_RD packed read addresses   (port i at [i*ADDR_W +: ADDR_W])
//   rd_data        NUM_RD packed read data        (port i at [i*DATA_W +: DATA_W])
//   rd_busy        busy bit of each read port's register
//   wr_en          per write port enable
//   wr_addr        NUM_WR packed write addresses
//   wr_data        NUM_WR packed write data
//   busy_set_en    mark busy_set_addr pending at the next edge
//   busy_set_addr  register to mark pending
//   busy_any       OR of all registered busy bits
//
// Handshake: there is no valid/ready flow control. An enabled write or busy
// set presented before a rising edge is always accepted at that edge (unless
// rst_n is low); reads are combinational and always valid.
//
// Configuration macro
//   REG_FILE_MP_BYPASS_EN  when defined, a read of a register being written in
//                          the same cycle returns the write data (highest write
//                          port wins) and a busy bit that only reflects a
//                          concurrent busy set. Undefined: reads show stored state.
// -----------------------------------------------------------------------------
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     busy_set_en,
    input  logic [ADDR_W-1:0]        busy_set_addr,
    output logic                     busy_any
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    logic [ADDR_W-1:0]   w_rd_addr [NUM_RD];
    logic                w_rd_ok   [NUM_RD];
    logic [ADDR_W-1:0]   w_wr_addr [NUM_WR];
    logic [DATA_W-1:0]   w_wr_data [NUM_WR];
    logic                w_wr_ok   [NUM_WR];
    logic                w_bs_ok;

    // An address names a real, writable register: inside the array (depth may
    // not be a power of two) and not the hardwired zero register.
    function automatic logic f_addr_ok(input logic [ADDR_W-1:0] a);
        logic w_in_range;
        logic w_is_zero;
        w_in_range = int'(a) < NUM_REGS;
        w_is_zero  = (ZERO_REG != 0) && (a == '0);
        return w_in_range && !w_is_zero;
    endfunction

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
        assign w_rd_addr[i] = rd_addr[i*ADDR_W +: ADDR_W];
        assign w_rd_ok[i]   = f_addr_ok(w_rd_addr[i]);
    end

    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr_unpack
        assign w_wr_addr[p] = wr_addr[p*ADDR_W +: ADDR_W];
        assign w_wr_data[p] = wr_data[p*DATA_W +: DATA_W];
        assign w_wr_ok[p]   = wr_en[p] && f_addr_ok(w_wr_addr[p]);
    end

    assign w_bs_ok = busy_set_en && f_addr_ok(busy_set_addr);

    // Register array. Ports are visited in ascending order, so the last
    // non-blocking assignment (highest port index) wins on an address clash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wr_ok[p]) begin
                    r_regs[w_wr_addr[p]] <= w_wr_data[p];
                end
            end
        end
    end

    // Scoreboard next state: writebacks clear, then a busy set is applied last
    // so a newly issued producer overrides a same-edge writeback.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int p = 0; p < NUM_WR; p++) begin
            if (w_wr_ok[p]) begin
                w_busy_nxt[w_wr_addr[p]] = 1'b0;
            end
        end
        if (w_bs_ok) begin
            w_busy_nxt[busy_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Combinational read. Invalid addresses (zero register, beyond depth)
    // leave the zero defaults in place.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (w_rd_ok[i]) begin
                rd_data[i*DATA_W +: DATA_W] = r_regs[w_rd_addr[i]];
                rd_busy[i]                  = r_busy[w_rd_addr[i]];
            end
`ifdef REG_FILE_MP_BYPASS_EN
            // Forward same-cycle writeback; later ports override earlier ones.
            // Gated by rst_n so reads stay 0 while reset is held.
            for (int p = 0; p < NUM_WR; p++) begin
                if (rst_n && w_rd_ok[i] && w_wr_ok[p] && (w_wr_addr[p] == w_rd_addr[i])) begin
                    rd_data[i*DATA_W +: DATA_W] = w_wr_data[p];
                    rd_busy[i] = w_bs_ok && (busy_set_addr == w_rd_addr[i]);
                end
            end
`endif
        end
    end

    assign busy_any = |r_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

`ifdef REG_FILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: 32 regs, 2 read, 2 write, zero register
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_bs_en;
  logic [4:0]  a_bs_addr;
  logic        a_busy_any;

  // DUT B: 24 regs, 1 read, 1 write, no zero register
  logic [4:0]  b_rd_addr;
  logic [31:0] b_rd_data;
  logic [0:0]  b_rd_busy;
  logic [0:0]  b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_bs_en;
  logic [4:0]  b_bs_addr;
  logic        b_busy_any;

  reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .busy_set_en(a_bs_en), .busy_set_addr(a_bs_addr), .busy_any(a_busy_any)
  );

  reg_file_mp #(.DATA_W(32), .NUM_REGS(24), .NUM_RD(1), .NUM_WR(1), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .busy_set_en(b_bs_en), .busy_set_addr(b_bs_addr), .busy_any(b_busy_any)
  );

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_v;
  logic [31:0] got_v;

  logic [31:0] mdl_a [32];
  logic [31:0] busy_a;
  logic [31:0] mdl_b [24];
  logic [23:0] busy_b;

  task automatic mdl_clear();
    for (int r = 0; r < 32; r++) mdl_a[r] = '0;
    for (int r = 0; r < 24; r++) mdl_b[r] = '0;
    busy_a = '0;
    busy_b = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    a_wr_en = '0;
    a_bs_en = 1'b0;
    b_wr_en = '0;
    b_bs_en = 1'b0;
  endtask

  // Advance one rising edge, updating the model from the inputs presented.
  task automatic tick();
    logic [31:0] na [32];
    logic [31:0] nb [24];
    logic [31:0] nba;
    logic [23:0] nbb;
    logic [4:0]  wa;
    na  = mdl_a;
    nb  = mdl_b;
    nba = busy_a;
    nbb = busy_b;
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        if (a_wr_en[p]) begin
          wa = a_wr_addr[p*5 +: 5];
          if (wa != 5'd0) begin
            na[wa]  = a_wr_data[p*32 +: 32];
            nba[wa] = 1'b0;
          end
        end
      end
      if (a_bs_en && a_bs_addr != 5'd0) nba[a_bs_addr] = 1'b1;
      if (b_wr_en[0] && b_wr_addr < 5'd24) begin
        nb[b_wr_addr]  = b_wr_data;
        nbb[b_wr_addr] = 1'b0;
      end
      if (b_bs_en && b_bs_addr < 5'd24) nbb[b_bs_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
    mdl_a  = na;
    mdl_b  = nb;
    busy_a = nba;
    busy_b = nbb;
    drive_idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // Still in reset from the top-level sequence.
    a_rd_addr = {5'd31, 5'd5};
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    checks++; exp_v = exp_q.pop_front(); got_v = a_rd_data[31:0];
    if (got_v !== exp_v) begin errors++; $display("FAIL reset_rd0: got %h exp %h", got_v, exp_v); end
    checks++; exp_v = exp_q.pop_front(); got_v = a_rd_data[63:32];
    if (got_v !== exp_v) begin errors++; $display("FAIL reset_rd1: got %h exp %h", got_v, exp_v); end
    checks++;
    if (a_busy_any !== 1'b0) begin errors++; $display("FAIL reset_busy_any: got %b exp 0", a_busy_any); end

    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write r5 and mark it busy at the same edge (set wins).
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd5; a_wr_data[31:0] = 32'hDEADBEEF;
    a_bs_en = 1'b1;  a_bs_addr = 5'd5;
    tick();
    a_rd_addr[4:0] = 5'd5;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    checks++; exp_v = exp_q.pop_front(); got_v = a_rd_data[31:0];
    if (got_v !== exp_v) begin errors++; $display("FAIL reset_pre_r5: got %h exp %h", got_v, exp_v); end
    checks++;
    if (a_busy_any !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: got %b exp 1", a_busy_any); end

    // Mid-cycle asynchronous reset: no clock edge needed.
    #1;
    rst_n = 1'b0;
    mdl_clear();
    exp_q.push_back(mdl_a[5]);
    #1;
    checks++; exp_v = exp_q.pop_front(); got_v = a_rd_data[31:0];
    if (got_v !== exp_v) begin errors++; $display("FAIL reset_async_r5: got %h exp %h", got_v, exp_v); end
    checks++;
    if (a_busy_any !== 1'b0 || a_rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL reset_async_busy: got any=%b rd=%b exp 0", a_busy_any, a_rd_busy[0]);
    end

    // Write and busy set under reset are lost.
    a_wr_en = 2'b10; a_wr_addr[9:5] = 5'd6; a_wr_data[63:32] = 32'h12345678;
    a_bs_en = 1'b1;  a_bs_addr = 5'd6;
    a_rd_addr[9:5] = 5'd6;
    #1;
    checks++; got_v = a_rd_data[63:32];
    if (got_v !== 32'h0) begin errors++; $display("FAIL reset_hold_rd: got %h exp 0", got_v); end
    tick();
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(mdl_a[6]);
    #1;
    checks++; exp_v = exp_q.pop_front(); got_v = a_rd_data[63:32];
    if (got_v !== exp_v) begin errors++; $display("FAIL reset_lost_write: got %h exp %h", got_v, exp_v); end
    checks++;
    if (a_busy_any !== 1'b0) begin errors++; $display("FAIL reset_lost_busy: got %b exp 0", a_busy_any); end
  endtask

  task automatic test_fill();
    for (int a = 0; a < 32; a++) begin
      a_wr_en = 2'b01; a_wr_addr[4:0] = a[4:0]; a_wr_data[31:0] = 32'hFFFFFFFF;
      tick();
    end
    for (int a = 0; a < 32; a++) begin
      int b;
      b = 31 - a;
      a_rd_addr = {b[4:0], a[4:0]};
      exp_q.push_back(mdl_a[a]);
      exp_q.push_back(mdl_a[b]);
      @(negedge clk);
      checks++; exp_v = exp_q.pop_front(); got_v = a_rd_data[31:0];
      if (got_v !== exp_v) begin errors++; $display("FAIL fill_p0 r%0d: got %h exp %h", a, got_v, exp_v); end
      checks++; exp_v = exp_q.pop_front(); got_v = a_rd_data[63:32];
      if (got_v !== exp_v) begin errors++; $display("FAIL fill_p1 r%0d: got %h exp %h", b, got_v, exp_v); end
    end
    // Disabled writes of zero must leave contents alone.
    for (int a = 0; a < 32; a++) begin
      a_wr_en = 2'b00; a_wr_addr = {a[4:0], a[4:0]}; a_wr_data = '0;
      tick();
    end
    for (int a = 0; a < 32; a++) begin
      a_rd_addr[4:0] = a[4:0];
      exp_q.push_back(mdl_a[a]);
      @(negedge clk);
      checks++; exp_v = exp_q.pop_front(); got_v = a_rd_data[31:0];
      if (got_v !== exp_v) begin errors++; $display("FAIL fill_noen r%0d: got %h exp %h", a, got_v, exp_v); end
    end
  endtask

  task automatic test_conflict();
    @(posedge clk); #1;
    a_wr_en = 2'b11; a_wr_addr = {5'd7, 5'd7}; a_wr_data = {32'h22222222, 32'h11111111};
    a_rd_addr[4:0] = 5'd7;
    exp_q.push_back(BYP ? 32'h22222222 : mdl_a[7]);
    #1;
    checks++; exp_v = exp_q.pop_front(); got_v = a_rd_data[31:0];
    if (got_v !== exp_v) begin errors++; $display("FAIL conflict_same_cycle: got %h exp %h", got_v, exp_v); end
    tick();
    exp_q.push_back(32'h22222222);
    @(negedge clk);
    checks++; exp_v = exp_q.pop_front(); got_v = a_rd_data[31:0];
    if (got_v !== exp_v) begin errors++; $display("FAIL conflict_r7: got %h exp %h", got_v, exp_v); end

    @(posedge clk); #1;
    a_wr_en = 2'b11; a_wr_addr = {5'd4, 5'd3}; a_wr_data = {32'h44444444, 32'h33333333};
    tick();
    a_rd_addr = {5'd4, 5'd3};
    exp_q.push_back(32'h33333333);
    exp_q.push_back(32'h44444444);
    @(negedge clk);
    checks++; exp_v = exp_q.pop_front(); got_v = a_rd_data[31:0];
    if (got_v !== exp_v) begin errors++; $display("FAIL distinct_r3: got %h exp %h", got_v, exp_v); end
    checks++; exp_v = exp_q.pop_front(); got_v = a_rd_data[63:32];
    if (got_v !== exp_v) begin errors++; $display("FAIL distinct_r4: got %h exp %h", got_v, exp_v); end
  endtask

  task automatic test_scoreboard();
    @(posedge clk); #1;
    a_rd_addr = {5'd0, 5'd9};
    a_bs_en = 1'b1; a_bs_addr = 5'd9;
    tick();                                   // edge 1
    exp_q.push_back({31'b0, busy_a[9]});
    @(negedge clk);
    checks++; exp_v = exp_q.pop_front();
    if ({31'b0, a_rd_busy[0]} !== exp_v || a_busy_any !== 1'b1) begin
      errors++; $display("FAIL sb_set: got busy=%b any=%b exp %0d/1", a_rd_busy[0], a_busy_any, exp_v);
    end
    tick();                                   // edge 2, idle
    checks++;
    if (a_rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_hold: got %b exp 1", a_rd_busy[0]); end

    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd9; a_wr_data[31:0] = 32'h00000099;
    exp_q.push_back(BYP ? 32'd0 : 32'd1);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if ({31'b0, a_rd_busy[0]} !== exp_v) begin
      errors++; $display("FAIL sb_wb_same_cycle: got %b exp %0d", a_rd_busy[0], exp_v);
    end
    tick();                                   // edge 3, writeback clears
    exp_q.push_back({31'b0, busy_a[9]});
    @(negedge clk);
    checks++; exp_v = exp_q.pop_front();
    if ({31'b0, a_rd_busy[0]} !== exp_v || a_busy_any !== 1'b0) begin
      errors++; $display("FAIL sb_clear: got busy=%b any=%b exp %0d/0", a_rd_busy[0], a_busy_any, exp_v);
    end

    @(posedge clk); #1;
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd9; a_wr_data[31:0] = 32'h000000AA;
    a_bs_en = 1'b1;  a_bs_addr = 5'd9;
    exp_q.push_back(BYP ? 32'd1 : 32'd0);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if ({31'b0, a_rd_busy[0]} !== exp_v) begin
      errors++; $display("FAIL sb_setwb_same_cycle: got %b exp %0d", a_rd_busy[0], exp_v);
    end
    tick();
    exp_q.push_back(32'd1);
    @(negedge clk);
    checks++; exp_v = exp_q.pop_front();
    if ({31'b0, a_rd_busy[0]} !== exp_v) begin errors++; $display("FAIL sb_set_wins: got %b exp %0d", a_rd_busy[0], exp_v); end

    @(posedge clk); #1;
    a_wr_en = 2'b10; a_wr_addr[9:5] = 5'd9; a_wr_data[63:32] = 32'h000000BB;
    tick();
    checks++;
    if (a_rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_clear2: got %b exp 0", a_rd_busy[0]); end

    a_bs_en = 1'b1; a_bs_addr = 5'd0;
    tick();
    @(negedge clk);
    checks++;
    if (a_rd_busy[1] !== 1'b0 || a_busy_any !== 1'b0) begin
      errors++; $display("FAIL sb_r0: got busy=%b any=%b exp 0/0", a_rd_busy[1], a_busy_any);
    end
  endtask

  task automatic test_bypass();
    @(posedge clk); #1;
    a_rd_addr = {5'd12, 5'd0};
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd12; a_wr_data[31:0] = 32'h0000ABCD;
    exp_q.push_back(BYP ? 32'h0000ABCD : mdl_a[12]);
    #1;
    checks++; exp_v = exp_q.pop_front(); got_v = a_rd_data[63:32];
    if (got_v !== exp_v) begin errors++; $display("FAIL bypass_same_cycle: got %h exp %h", got_v, exp_v); end
    tick();
    exp_q.push_back(32'h0000ABCD);
    @(negedge clk);
    checks++; exp_v = exp_q.pop_front(); got_v = a_rd_data[63:32];
    if (got_v !== exp_v) begin errors++; $display("FAIL bypass_after: got %h exp %h", got_v, exp_v); end

    @(posedge clk); #1;
    a_wr_en = 2'b10; a_wr_addr[9:5] = 5'd0; a_wr_data[63:32] = 32'h77777777;
    #1;
    checks++; got_v = a_rd_data[31:0];
    if (got_v !== 32'h0) begin errors++; $display("FAIL bypass_r0: got %h exp 0", got_v); end
    tick();
    checks++; got_v = a_rd_data[31:0];
    if (got_v !== 32'h0) begin errors++; $display("FAIL zero_reg_r0: got %h exp 0", got_v); end
  endtask

  task automatic test_params();
    @(posedge clk); #1;
    b_rd_addr = 5'd0;
    b_wr_en = 1'b1; b_wr_addr = 5'd0; b_wr_data = 32'h5A5A5A5A;
    exp_q.push_back(BYP ? 32'h5A5A5A5A : mdl_b[0]);
    #1;
    checks++; exp_v = exp_q.pop_front(); got_v = b_rd_data;
    if (got_v !== exp_v) begin errors++; $display("FAIL nz_r0_same_cycle: got %h exp %h", got_v, exp_v); end
    tick();
    exp_q.push_back(32'h5A5A5A5A);
    @(negedge clk);
    checks++; exp_v = exp_q.pop_front(); got_v = b_rd_data;
    if (got_v !== exp_v) begin errors++; $display("FAIL nz_r0: got %h exp %h", got_v, exp_v); end

    // Register 0 is ordinary here, so it can be marked busy.
    @(posedge clk); #1;
    b_bs_en = 1'b1; b_bs_addr = 5'd0;
    tick();
    exp_q.push_back({31'b0, busy_b[0]});
    @(negedge clk);
    checks++; exp_v = exp_q.pop_front();
    if ({31'b0, b_rd_busy[0]} !== exp_v || b_busy_any !== 1'b1) begin
      errors++; $display("FAIL nz_r0_busy: got busy=%b any=%b exp %0d/1", b_rd_busy[0], b_busy_any, exp_v);
    end

    @(posedge clk); #1;
    b_wr_en = 1'b1; b_wr_addr = 5'd0; b_wr_data = 32'h5A5A5A5B;
    tick();
    b_rd_addr = 5'd30;
    b_wr_en = 1'b1; b_wr_addr = 5'd30; b_wr_data = 32'hCAFEF00D;
    b_bs_en = 1'b1; b_bs_addr = 5'd30;
    #1;
    checks++; got_v = b_rd_data;
    if (got_v !== 32'h0 || b_rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL oor_same_cycle: got %h/%b exp 0/0", got_v, b_rd_busy[0]);
    end
    tick();
    @(negedge clk);
    checks++; got_v = b_rd_data;
    if (got_v !== 32'h0 || b_rd_busy[0] !== 1'b0 || b_busy_any !== 1'b0) begin
      errors++; $display("FAIL oor_dropped: got %h/%b/%b exp 0/0/0", got_v, b_rd_busy[0], b_busy_any);
    end

    @(posedge clk); #1;
    b_rd_addr = 5'd23;
    b_wr_en = 1'b1; b_wr_addr = 5'd23; b_wr_data = 32'($urandom_range(32'h7FFFFFFF, 1));
    tick();
    exp_q.push_back(mdl_b[23]);
    @(negedge clk);
    checks++; exp_v = exp_q.pop_front(); got_v = b_rd_data;
    if (got_v !== exp_v) begin errors++; $display("FAIL nz_r23: got %h exp %h", got_v, exp_v); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n = 1'b0;
    a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_bs_addr = '0;
    b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_bs_addr = '0;
    drive_idle();
    mdl_clear();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_conflict();
    test_scoreboard();
    test_bypass();
    test_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout exp completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the RV32I core datapath.
- Generalises the 2-read/1-write integer register file to N read ports, M write ports and configurable width/depth.
- Adds asynchronous reset and a per-register busy scoreboard, so a multi-issue or long-latency pipeline can track pending writebacks.
- Sits between decode (read and busy-set side) and writeback (write side).

Parameters:
- DATA_W, 32: register width in bits.
- NUM_REGS, 32: number of architectural registers. Must be 2 or more. ADDR_W = $clog2(NUM_REGS) is a derived localparam.
- NUM_RD, 2: number of read ports, 1 or more.
- NUM_WR, 1: number of write ports, 1 or more.
- ZERO_REG, 1: 1 means register 0 is hardwired to zero. 0 means register 0 is an ordinary register.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- rd_addr, in, NUM_RD*ADDR_W: read addresses; port i occupies slice [i*ADDR_W +: ADDR_W].
- rd_data, out, NUM_RD*DATA_W: read data, packed the same way.
- rd_busy, out, NUM_RD: busy bit of the register addressed by each read port.
- wr_en, in, NUM_WR: per-port write enable.
- wr_addr, in, NUM_WR*ADDR_W: write addresses.
- wr_data, in, NUM_WR*DATA_W: write data.
- busy_set_en, in, 1: mark a register as pending at the next edge.
- busy_set_addr, in, ADDR_W: register to mark pending.
- busy_any, out, 1: OR of all busy bits.

Behaviour:
- Reset:
  - rst_n low immediately clears every register to 0 and every busy bit to 0. This is asynchronous and needs no clock edge.
  - While rst_n is low, rd_data reads 0, rd_busy is 0 and busy_any is 0.
  - Writes and busy sets presented while rst_n is low are ignored.
  - Deassertion is sampled on the next rising edge.
  - Reset asserted in the middle of a write cycle: the write is lost and the register stays 0.
- Read:
  - Purely combinational; zero latency from rd_addr to rd_data.
  - With ZERO_REG=1, address 0 always returns 0 and its rd_busy is 0.
  - An address of NUM_REGS or above (non-power-of-2 depth) returns 0 data and busy 0.
- Write:
  - At a rising edge, each port p with wr_en[p]=1 writes wr_data[p] to wr_addr[p].
  - With ZERO_REG=1, writes to address 0 are discarded. Out-of-range addresses are discarded.
  - If several enabled ports target the same address in one cycle, the highest port index wins.
  - A written value is visible on rd_data in the cycle after the edge, unless BYPASS_EN is defined (see Optional Feature).
- Scoreboard:
  - busy_set_en=1 at an edge sets busy[busy_set_addr].
  - Each enabled write at an edge clears busy[wr_addr[p]].
  - Set and clear of the same register at the same edge: set wins, because a new producer has been issued.
  - With ZERO_REG=1, busy[0] is never set.
  - Writes to non-busy registers are legal and leave busy unchanged.
  - rd_busy[i] = busy[rd_addr[i]], combinational.
  - busy_any is combinational.

Optional Feature:
- Macro: REG_FILE_MP_BYPASS_EN.
- Defined (write-through bypass):
  - If any enabled write port targets a read port's address in the current cycle, rd_data returns that port's wr_data combinationally. Highest write-port index wins.
  - The matching rd_busy reads 0 in that cycle unless busy_set_en targets the same address.
  - Address 0 is still forced to 0 when ZERO_REG=1.
- Undefined:
  - Reads return the stored value until after the edge.
  - rd_busy reflects the registered bit only.

Test Plan:
1. Reset and read: assert rst_n=0 mid-cycle after writing 0xDEADBEEF to r5 -> r5 reads 0 immediately without a clock edge; busy_any=0.
2. Fill and check: write 0xFFFFFFFF to r0..r31 on port 0, then read all registers on every read port -> r0=0, r1..r31=0xFFFFFFFF. Repeat with wr_en=0 and data 0 -> values unchanged.
3. Write conflict: NUM_WR=2, both ports write r7 in the same cycle (0x11111111 on port 0, 0x22222222 on port 1) -> r7=0x22222222 next cycle. Distinct addresses r3/r4 -> both written.
4. Scoreboard:
   - busy_set r9 at edge 1 -> rd_busy=1 and busy_any=1.
   - Write r9 at edge 3 -> busy clears after edge 3.
   - Set and write r9 at the same edge -> busy stays 1.
   - busy_set r0 -> no effect.
5. Bypass: write 0x0000ABCD to r12 while reading r12 -> with REG_FILE_MP_BYPASS_EN, rd_data=0x0000ABCD in the same cycle; without it, the old value in that cycle and 0x0000ABCD after the edge.
6. ZERO_REG=0, NUM_REGS=24: write 0x5A5A5A5A to r0 -> r0 reads 0x5A5A5A5A. Read address 30 -> data 0, busy 0; a write to address 30 is dropped.
